// File: rtl/dvp_tx_pkg.sv
// Shared FSM states, default timing and the RGB565 colour-bar table
// for the DVP frame transmitter.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } dvp_state_e;

    localparam int DEF_H_ACTIVE  = 320;
    localparam int DEF_V_ACTIVE  = 240;
    localparam int DEF_H_BLANK   = 64;
    localparam int DEF_VSYNC_LEN = 3;
    localparam int DEF_V_BACK    = 17;
    localparam int DEF_V_FRONT   = 10;

    // Entry 0 is the leftmost bar: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [7:0][15:0] BAR_TABLE = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_tx_colorbar.sv
// Eight-bar RGB565 pattern source; advances one pixel per slot and
// restarts at bar 0 whenever clr is high (outside active video).
module dvp_tx_colorbar
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        cam_pclk,
    input  logic        rst,
    input  logic        clr,
    input  logic        adv,
    output logic [15:0] rgb
);

    localparam int BAR_W = max_int(H_ACTIVE / 8, 1);
    localparam int WW    = max_int($clog2(BAR_W), 1);
    localparam logic [WW-1:0] W_END = WW'(BAR_W - 1);

    logic [WW-1:0] w_cnt;
    logic [2:0]    bar;

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            w_cnt <= '0;
            bar   <= '0;
        end else if (clr) begin
            w_cnt <= '0;
            bar   <= '0;
        end else if (adv) begin
            if (w_cnt == W_END) begin
                w_cnt <= '0;
                // Leftover pixels when H_ACTIVE is not a multiple of 8
                // stay on the last bar.
                if (bar != 3'd7)
                    bar <= bar + 3'd1;
            end else begin
                w_cnt <= w_cnt + 1'b1;
            end
        end
    end

    assign rgb = BAR_TABLE[bar];

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP camera-side frame transmitter: RGB565 pixels in, vsync/href/bytes out.
// Define DVP_TX_TESTPAT_EN to add test_mode and the colour-bar source.
module dvp_frame_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_FRONT   = DEF_V_FRONT
) (
    input  logic        cam_pclk,
    input  logic        rst,
    input  logic        enable,
`ifdef DVP_TX_TESTPAT_EN
    input  logic        test_mode,
`endif
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underrun
);

    localparam int L      = 2 * H_ACTIVE + H_BLANK;
    localparam int V_MAX  = max_int(max_int(VSYNC_LEN, V_BACK), V_FRONT);
    localparam int PH_MAX = max_int(V_MAX * L, L);
    localparam int CW     = max_int($clog2(PH_MAX), 1);
    localparam int LW     = max_int($clog2(V_ACTIVE), 1);

    localparam logic [CW-1:0] VS_END  = CW'(VSYNC_LEN * L - 1);
    localparam logic [CW-1:0] VB_END  = CW'(V_BACK * L - 1);
    localparam logic [CW-1:0] VF_END  = CW'(V_FRONT * L - 1);
    localparam logic [CW-1:0] ACT_END = CW'(2 * H_ACTIVE - 1);
    localparam logic [CW-1:0] HB_END  = CW'(H_BLANK - 1);
    localparam logic [LW-1:0] LN_END  = LW'(V_ACTIVE - 1);

    dvp_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [LW-1:0] line_cnt, line_nxt;
    logic          start_req;

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            line_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            line_cnt <= line_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        line_nxt   = line_cnt;
        start_req  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = VSYNC;
                    start_req = 1'b1;
                end
            end
            VSYNC: begin
                if (cnt == VS_END) begin
                    state_nxt = VBACK;
                    cnt_nxt   = '0;
                end
            end
            VBACK: begin
                if (cnt == VB_END) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                    line_nxt  = '0;
                end
            end
            ACTIVE: begin
                if (cnt == ACT_END) begin
                    state_nxt = HBLANK;
                    cnt_nxt   = '0;
                end
            end
            HBLANK: begin
                if (cnt == HB_END) begin
                    cnt_nxt = '0;
                    if (line_cnt == LN_END) begin
                        state_nxt = VFRONT;
                        line_nxt  = '0;
                    end else begin
                        state_nxt = ACTIVE;
                        line_nxt  = line_cnt + 1'b1;
                    end
                end
            end
            VFRONT: begin
                if (cnt == VF_END) begin
                    frame_done = 1'b1;
                    cnt_nxt    = '0;
                    // enable is only sampled here, so a drop never
                    // truncates a frame in flight.
                    if (enable) begin
                        state_nxt = VSYNC;
                        start_req = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
        endcase
    end

    // IDLE is also the reset state, so mask the pulse while rst is held.
    assign frame_start = start_req & ~rst;

    logic        slot;
    logic        odd_byte;
    logic        src_valid;
    logic [15:0] src_data;
    logic [7:0]  lo_byte;

    assign slot     = (state == ACTIVE) && !cnt[0];
    assign odd_byte = (state == ACTIVE) &&  cnt[0];

`ifdef DVP_TX_TESTPAT_EN
    logic [15:0] bar_rgb;

    dvp_tx_colorbar #(
        .H_ACTIVE (H_ACTIVE)
    ) u_colorbar (
        .cam_pclk (cam_pclk),
        .rst      (rst),
        .clr      (state != ACTIVE),
        .adv      (slot),
        .rgb      (bar_rgb)
    );

    assign src_valid = test_mode | pix_valid;
    assign src_data  = test_mode ? bar_rgb : pix_data;
    assign pix_ready = slot & ~test_mode;
`else
    assign src_valid = pix_valid;
    assign src_data  = pix_data;
    assign pix_ready = slot;
`endif

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            cam_vsync <= 1'b0;
            cam_href  <= 1'b0;
            cam_data  <= '0;
            lo_byte   <= '0;
            underrun  <= 1'b0;
        end else begin
            cam_vsync <= (state == VSYNC);
            cam_href  <= (state == ACTIVE);
            underrun  <= slot & ~src_valid;
            if (slot) begin
                cam_data <= src_valid ? src_data[15:8] : 8'h00;
                lo_byte  <= src_valid ? src_data[7:0]  : 8'h00;
            end else if (odd_byte) begin
                cam_data <= lo_byte;
            end else begin
                cam_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Randomised bench for dvp_frame_tx against a frame-timeline model.
// Define DVP_TX_TESTPAT_EN to also check the colour-bar path.
module tb_dvp_frame_tx;

    localparam int H  = 4;
    localparam int VA = 2;
    localparam int HB = 3;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * H + HB;
    localparam int F  = (VS + VB + VA + VF) * L;

    logic        cam_pclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_start;
    logic        frame_done;
    logic        underrun;
`ifdef DVP_TX_TESTPAT_EN
    logic        test_mode;
`endif

    always #5 cam_pclk = ~cam_pclk;

    dvp_frame_tx #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (VA),
        .H_BLANK   (HB),
        .VSYNC_LEN (VS),
        .V_BACK    (VB),
        .V_FRONT   (VF)
    ) u_dut (
        .cam_pclk    (cam_pclk),
        .rst         (rst),
        .enable      (enable),
`ifdef DVP_TX_TESTPAT_EN
        .test_mode   (test_mode),
`endif
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame timeline: k=-1 idle, k=1..F are the cycles after a start.
    int         k = -1;
    int         pk = -1;
    logic [7:0] hi_b = 8'h00;
    logic [7:0] lo_b = 8'h00;
    bit         und_pend = 1'b0;
    int         n_vs, n_ur, n_done, n_start;

    function automatic int act_idx(input int kk);
        int j;
        if (kk < 1) return -1;
        j = kk - 1 - (VS + VB) * L;
        if (j < 0 || j >= VA * L) return -1;
        if ((j % L) >= 2 * H) return -1;
        return j % L;
    endfunction

    function automatic int line_of(input int kk);
        if (act_idx(kk) < 0) return -1;
        return (kk - 1 - (VS + VB) * L) / L;
    endfunction

    function automatic bit in_vs(input int kk);
        return (kk >= 1) && (kk <= VS * L);
    endfunction

    task automatic model_reset();
        k = -1;
        pk = -1;
        hi_b = 8'h00;
        lo_b = 8'h00;
        und_pend = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vsync"}, cam_vsync, 1'b0);
        chk({tag, "_href"}, cam_href, 1'b0);
        chk({tag, "_data"}, cam_data, 8'h00);
        chk({tag, "_ready"}, pix_ready, 1'b0);
        chk({tag, "_start"}, frame_start, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
    endtask

    // mode 0: always valid, 1: A55A in slot 0, 2: gap in 3rd slot of
    // line 0, 3: random valid.
    task automatic cyc(input bit en, input int mode);
        int ai, pi;
        bit v, rdy, st, dn;
        logic [15:0] d;
        logic [7:0] exp_d;
        ai = act_idx(k);
        v  = 1'b1;
        d  = 16'($urandom);
        if (mode == 1 && ai == 0) d = 16'hA55A;
        if (mode == 2 && ai == 4 && line_of(k) == 0) v = 1'b0;
        if (mode == 3) v = ($urandom_range(3) != 0);
        @(negedge cam_pclk);
        enable    = en;
        pix_valid = v;
        pix_data  = d;
        #1;
        st  = (k < 0) ? en : ((k == F) && en);
        dn  = (k == F);
        rdy = (ai >= 0) && (ai % 2 == 0);
        pi  = act_idx(pk);
        exp_d = (pi < 0) ? 8'h00 : ((pi % 2 == 0) ? hi_b : lo_b);
        chk("frame_start", frame_start, st);
        chk("frame_done", frame_done, dn);
        chk("pix_ready", pix_ready, rdy);
        chk("cam_vsync", cam_vsync, in_vs(pk));
        chk("cam_href", cam_href, pi >= 0);
        chk("cam_data", cam_data, exp_d);
        chk("underrun", underrun, und_pend);
        if (mode == 1 && pi == 0) chk("a55a_hi", cam_data, 8'hA5);
        if (mode == 1 && pi == 1) chk("a55a_lo", cam_data, 8'h5A);
        n_vs    += int'(cam_vsync);
        n_ur    += int'(underrun);
        n_done  += int'(frame_done);
        n_start += int'(frame_start);
        und_pend = rdy && !v;
        if (rdy) begin
            hi_b = v ? d[15:8] : 8'h00;
            lo_b = v ? d[7:0]  : 8'h00;
        end
        pk = k;
        if (st) k = 1;
        else if (k < 0 || k == F) k = -1;
        else k++;
    endtask

    task automatic run(input int n, input bit en, input int mode);
        n_vs = 0;
        n_ur = 0;
        n_done = 0;
        n_start = 0;
        for (int i = 0; i < n; i++) cyc(en, mode);
    endtask

`ifdef DVP_TX_TESTPAT_EN
    logic       tp_ready, tp_vsync, tp_href, tp_start, tp_done, tp_und;
    logic [7:0] tp_data;

    dvp_frame_tx #(
        .H_ACTIVE  (8),
        .V_ACTIVE  (VA),
        .H_BLANK   (HB),
        .VSYNC_LEN (VS),
        .V_BACK    (VB),
        .V_FRONT   (VF)
    ) u_tp (
        .cam_pclk    (cam_pclk),
        .rst         (rst),
        .enable      (1'b1),
        .test_mode   (1'b1),
        .pix_valid   (1'b0),
        .pix_data    (16'h0000),
        .pix_ready   (tp_ready),
        .cam_vsync   (tp_vsync),
        .cam_href    (tp_href),
        .cam_data    (tp_data),
        .frame_start (tp_start),
        .frame_done  (tp_done),
        .underrun    (tp_und)
    );

    task automatic tp_test();
        logic [15:0] bars [8];
        logic [7:0]  hb;
        int          nb, lines;
        bit          armed, was_href;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        nb = 0;
        lines = 0;
        armed = 1'b0;
        was_href = 1'b0;
        hb = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge cam_pclk);
            #1;
            chk("tp_ready", tp_ready, 1'b0);
            chk("tp_underrun", tp_und, 1'b0);
            if (!tp_href) begin
                if (armed && was_href) begin
                    chk("tp_line_len", 16'(nb), 16'd16);
                    lines++;
                end
                armed = 1'b1;
                nb = 0;
            end else if (armed) begin
                if (nb % 2 == 0) hb = tp_data;
                else if (nb / 2 < 8)
                    chk("tp_bar", {hb, tp_data}, bars[nb / 2]);
                nb++;
            end
            was_href = tp_href;
        end
        chk("tp_lines", 16'(lines >= 2), 16'd1);
    endtask
`endif

    initial begin
        bit found;
        rst       = 1'b1;
        enable    = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 16'h0000;
`ifdef DVP_TX_TESTPAT_EN
        test_mode = 1'b0;
`endif
        #3;
        chk_all_zero("rst0");
        @(negedge cam_pclk);
        #1;
        chk_all_zero("rst_hold");
        enable = 1'b0;
        @(negedge cam_pclk);
        rst = 1'b0;
        model_reset();

        run(F + 1, 1'b1, 1);
        chk("vsync_len", 16'(n_vs), 16'(VS * L));
        chk("frame1_done", 16'(n_done), 16'd1);

        run(F, 1'b1, 2);
        chk("gap_underruns", 16'(n_ur), 16'd1);

        run(3 * F, 1'b1, 3);

        run(30, 1'b1, 3);
        run(F + 20, 1'b0, 3);
        chk("drop_vsync", 16'(n_vs), 16'd0);
        chk("drop_done", 16'(n_done), 16'd1);
        chk("drop_idle", 16'(k), 16'hFFFF);

        found = 1'b0;
        for (int i = 0; i < 4 * F && !found; i++) begin
            cyc(1'b1, 0);
            found = (line_of(pk) == 1);
        end
        chk("reach_line2", 16'(found), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge cam_pclk);
        #1;
        chk_all_zero("rst_mid_hold");
        enable = 1'b0;
        @(negedge cam_pclk);
        rst = 1'b0;
        model_reset();

        run(F, 1'b1, 0);
        chk("post_rst_start", 16'(n_start), 16'd1);
        chk("post_rst_vsync", 16'(n_vs), 16'(VS * L));

`ifdef DVP_TX_TESTPAT_EN
        tp_test();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
